// File: rtl/addsub_checker.sv
// addsub_checker: runs N_VECT observed vectors of a half add/sub unit against
// a golden model, counting mismatches and capturing the first failing vector.
`default_nettype none

module addsub_checker #(
  parameter int N_VECT = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             select,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [CNT_W-1:0] fail_idx,
  output logic [4:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state, state_nxt;

  logic exp_sum;
  logic exp_carry;
  logic mismatch;
  logic accept;
  logic clear;
  logic last_accept;

  // Carry for add, borrow for subtract; the sum bit is identical for both.
  assign exp_sum     = a ^ b;
  assign exp_carry   = select ? (~a & b) : (a & b);
  assign mismatch    = {sum, carry} != {exp_sum, exp_carry};

  assign accept      = in_valid & (state == RUN);
  assign clear       = start & ((state == IDLE) | (state == DONE));
  assign last_accept = accept & (vec_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)       state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DONE;
      DONE:    if (start)       state_nxt = RUN;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_vec   <= '0;
    end else if (clear) begin
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_vec   <= '0;
    end else if (accept) begin
      if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_ONE;
      if (mismatch && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
      // Only the first failure of a run is captured.
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_idx   <= vec_count;
        fail_vec   <= {a, b, select, sum, carry};
      end
    end
  end

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = (state == DONE) & (err_count == '0);

endmodule

`default_nettype wire
